// File: rtl/mem_resp_pkg.sv
// Shared types for the memory responder: FSM states, latched request bundle
// and bus width constants.
package mem_resp_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } mem_resp_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              is_write;
        logic [STRB_W-1:0] wmask;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_sram_array.sv
// Word-organised byte-writable storage: one synchronous write port with
// byte enables and a combinational read of the same index.
// Ports: clk, we_i, idx_i, wmask_i, wdata_i -> rdata_o.
module mem_sram_array
    import mem_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [STRB_W-1:0] wmask_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wmask_i[i]) begin
                    mem[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    assign rdata_o = mem[idx_i];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the core's mem_* bus with fixed response latency.
// Ports: clk, rst_n, mem_addr/read/write/wmask/wdata in; mem_rdata, mem_resp,
// err (sticky) out.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h4000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mem_addr,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [3:0]  mem_wmask,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_resp,
    output logic        err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY);

    mem_resp_state_t  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    mem_req_t         req_q, req_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             bad_q, bad_d;
    logic             err_q, err_d;

    logic [29:0]       woff;
    logic              in_range;
    logic              req_any;
    logic              arr_we;
    logic [DATA_W-1:0] arr_rdata;

    // Word offset from the base; a borrow shows up as addr < BASE_ADDR.
    assign woff     = mem_addr[31:2] - BASE_ADDR[31:2];
    assign in_range = (mem_addr[31:2] >= BASE_ADDR[31:2]) &&
                      ((woff >> IDX_W) == '0);
    assign req_any  = mem_read | mem_write;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        idx_d   = idx_q;
        bad_d   = bad_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_any) begin
                    req_d.addr     = mem_addr;
                    req_d.is_write = mem_write;
                    req_d.wmask    = mem_wmask;
                    req_d.wdata    = mem_wdata;
                    idx_d          = woff[IDX_W-1:0];
                    bad_d          = !in_range || (mem_read && mem_write);
                    err_d          = err_q | !in_range |
                                     (mem_read & mem_write);
                    cnt_d          = CNT_W'(LATENCY - 1);
                    state_d        = (LATENCY == 1) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                // A dropped request aborts even on the last wait cycle.
                if (!req_any) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    if (mem_addr != req_q.addr) begin
                        err_d = 1'b1;
                    end
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            idx_q   <= '0;
            bad_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            idx_q   <= idx_d;
            bad_q   <= bad_d;
            err_q   <= err_d;
        end
    end

    // Commit on the edge closing RESP; reset on that edge cancels it.
    assign arr_we = rst_n && (state_q == S_RESP) &&
                    req_q.is_write && !bad_q;

    mem_sram_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk    (clk),
        .we_i   (arr_we),
        .idx_i  (idx_q),
        .wmask_i(req_q.wmask),
        .wdata_i(req_q.wdata),
        .rdata_o(arr_rdata)
    );

    assign mem_resp  = (state_q == S_RESP);
    assign mem_rdata = (mem_resp && !req_q.is_write && !bad_q) ?
                       arr_rdata : '0;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: driver pushes expected response cycle
// and data, a negedge monitor pops and compares on every mem_resp.
module tb_mem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] mem_addr = 32'h4000_0000;
    logic        mem_read = 1'b1;
    logic        mem_write = 1'b0;
    logic [3:0]  mem_wmask = 4'h0;
    logic [31:0] mem_wdata = 32'h0;
    logic [31:0] mem_rdata;
    logic        mem_resp;
    logic        err;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        bit          chk;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    mem_responder #(
        .BASE_ADDR  (32'h4000_0000),
        .DEPTH_WORDS(1024),
        .LATENCY    (LAT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mem_addr (mem_addr),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .mem_wmask(mem_wmask),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_resp (mem_resp),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_resp) begin
            checks++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_resp cyc=%0d", cyc);
            end else begin
                e = sb.pop_front();
                if (cyc != e.cyc) begin
                    fails++;
                    $display("FAIL resp_cycle actual=%0d expected=%0d",
                             cyc, e.cyc);
                end
                if (e.chk) begin
                    checks++;
                    if (mem_rdata !== e.rdata) begin
                        fails++;
                        $display("FAIL rdata actual=%h expected=%h",
                                 mem_rdata, e.rdata);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic wait_resp();
        int n;
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (mem_resp) break;
        end
        if (n == 20) begin
            checks++;
            fails++;
            $display("FAIL resp_timeout cyc=%0d", cyc);
        end
    endtask

    // mode 0: normal, 1: drop request in WAIT, 2: change addr in WAIT
    task automatic do_req(input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] wm, input logic [31:0] exp,
                          input bit c, input int mode);
        @(posedge clk);
        #1;
        mem_read  = rd;
        mem_write = wr;
        mem_addr  = a;
        mem_wdata = wd;
        mem_wmask = wm;
        if (mode != 1) sb.push_back('{cyc + LAT, exp, c});
        if (mode == 1) begin
            @(posedge clk);
            #1;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            repeat (5) @(posedge clk);
            #1;
        end else begin
            if (mode == 2) begin
                @(posedge clk);
                #1;
                mem_addr = a + 32'd4;
            end
            wait_resp();
        end
    endtask

    task automatic wr_w(input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] m);
        do_req(1'b0, 1'b1, a, d, m, 32'h0, 1'b0, 0);
    endtask

    task automatic rd_w(input logic [31:0] a, input logic [31:0] exp);
        do_req(1'b1, 1'b0, a, 32'h0, 4'h0, exp, 1'b1, 0);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("err_after_reset", {31'h0, err}, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // 1: reset held with a read pending
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_resp", {31'h0, mem_resp}, 32'h0);
            chk("rst_rdata", mem_rdata, 32'h0);
            chk("rst_err", {31'h0, err}, 32'h0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.push_back('{cyc + LAT, 32'h0, 1'b0});
        wait_resp();

        // 2: full word write and read back
        wr_w(32'h4000_0010, 32'hDEAD_BEEF, 4'hF);
        rd_w(32'h4000_0010, 32'hDEAD_BEEF);

        // 3: byte lane write, then an empty mask
        wr_w(32'h4000_0010, 32'h1122_3344, 4'hF);
        wr_w(32'h4000_0012, 32'h00AB_0000, 4'b0100);
        rd_w(32'h4000_0010, 32'h11AB_3344);
        wr_w(32'h4000_0010, 32'hFFFF_FFFF, 4'b0000);
        rd_w(32'h4000_0010, 32'h11AB_3344);

        // 4: program image, back-to-back transactions
        wr_w(32'h4000_0000, 32'h0000_0093, 4'hF);
        wr_w(32'h4000_0004, 32'h0010_0113, 4'hF);
        wr_w(32'h4000_0008, 32'h0020_81B3, 4'hF);
        wr_w(32'h4000_000C, 32'h0000_006F, 4'hF);
        rd_w(32'h4000_0000, 32'h0000_0093);
        rd_w(32'h4000_0004, 32'h0010_0113);
        rd_w(32'h4000_0008, 32'h0020_81B3);
        rd_w(32'h4000_000C, 32'h0000_006F);
        idle();
        chk("err_clean", {31'h0, err}, 32'h0);

        // 5: out of range below base and past the end
        rd_w(32'h3FFF_FFFC, 32'h0);
        idle();
        chk("err_oor_read", {31'h0, err}, 32'h1);
        wr_w(32'h4000_1000, 32'hCAFE_F00D, 4'hF);
        rd_w(32'h4000_0000, 32'h0000_0093);
        idle();
        chk("err_sticky", {31'h0, err}, 32'h1);

        // 6a: write dropped during WAIT
        do_reset();
        do_req(1'b0, 1'b1, 32'h4000_0010, 32'h0BAD_F00D, 4'hF,
               32'h0, 1'b0, 1);
        chk("err_drop", {31'h0, err}, 32'h1);
        rd_w(32'h4000_0010, 32'h11AB_3344);

        // 6b: read and write together
        do_reset();
        do_req(1'b1, 1'b1, 32'h4000_0010, 32'hFFFF_FFFF, 4'hF,
               32'h0, 1'b1, 0);
        idle();
        chk("err_rdwr", {31'h0, err}, 32'h1);
        rd_w(32'h4000_0010, 32'h11AB_3344);

        // 6c: address changes while waiting; latched request completes
        do_reset();
        do_req(1'b1, 1'b0, 32'h4000_0010, 32'h0, 4'h0,
               32'h11AB_3344, 1'b1, 2);
        idle();
        chk("err_addr_chg", {31'h0, err}, 32'h1);

        repeat (4) @(posedge clk);
        #1;
        chk("sb_empty", sb.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
